// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/sequencing stage for the 8-bit ALU.
// Fetches 8-bit instructions from a combinational ROM and holds a 4x8 register
// file. Each ALU instruction presents operands/mode with alu_enable for one
// cycle (EXEC), then writes the ALU's registered result back in WB.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   imem_addr/data     instruction ROM address (= pc) and returned byte
//   alu_enable/mode/a/b  registered ALU controls and operands
//   alu_out            ALU registered result
//   alu_flag_zero/carry  live ALU flags used by conditional jumps
//   pc, halted         program counter and HALT indication
//   dbg_sel/dbg_reg    combinational register-file read port
module control_unit (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic       alu_enable,
  output logic [2:0] alu_mode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic       alu_flag_zero,
  input  logic       alu_flag_carry,
  output logic [3:0] pc,
  output logic       halted,
  input  logic [1:0] dbg_sel,
  output logic [7:0] dbg_reg
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [7:0]  ir;
  logic [7:0]  regs [4];

  logic [3:0]  pc_next;
  logic        ir_load;
  logic        reg_we;
  logic [1:0]  reg_wa;
  logic [7:0]  reg_wd;
  logic        alu_load;
  logic        alu_enable_next;
  logic        jmp_take;
  logic [2:0]  mode_dec;

  // Instruction fields
  logic [1:0]  cls;
  logic [1:0]  fn;
  logic [1:0]  rd;
  logic [1:0]  rs;

  assign cls = ir[7:6];
  assign fn  = ir[5:4];
  assign rd  = ir[3:2];
  assign rs  = ir[1:0];

  assign imem_addr = pc;
  assign halted    = (state == S_HALT);
  assign dbg_reg   = regs[dbg_sel];

  always_comb begin
    case (fn)
      2'b00:   mode_dec = OP_ADD;
      2'b01:   mode_dec = OP_SUB;
      2'b10:   mode_dec = OP_AND;
      default: mode_dec = OP_OR;
    endcase
  end

  always_comb begin
    case (fn)
      2'b00:   jmp_take = 1'b1;
      2'b01:   jmp_take = alu_flag_zero;
      2'b10:   jmp_take = alu_flag_carry;
      default: jmp_take = ~alu_flag_zero;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    ir_load         = 1'b0;
    reg_we          = 1'b0;
    reg_wa          = '0;
    reg_wd          = '0;
    alu_load        = 1'b0;
    alu_enable_next = 1'b0;
    case (state)
      S_FETCH: begin
        ir_load    = 1'b1;
        pc_next    = pc + 4'd1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        case (cls)
          2'b00: begin
            alu_load        = 1'b1;
            alu_enable_next = 1'b1;
            state_next      = S_EXEC;
          end
          2'b01: begin
            reg_we     = 1'b1;
            reg_wa     = ir[5:4];
            reg_wd     = {4'b0000, ir[3:0]};
            state_next = S_FETCH;
          end
          2'b10: begin
            if (jmp_take) pc_next = ir[3:0];
            state_next = S_FETCH;
          end
          default: begin
            state_next = (ir == 8'hFF) ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        // alu_enable_next defaults to 0, closing the single-cycle pulse
        state_next = S_WB;
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_wa     = rd;
        reg_wd     = alu_out;
        state_next = S_FETCH;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      ir         <= '0;
      alu_enable <= 1'b0;
      alu_mode   <= OP_ADD;
      alu_a      <= '0;
      alu_b      <= '0;
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      pc         <= pc_next;
      alu_enable <= alu_enable_next;
      if (ir_load) ir <= imem_data;
      if (reg_we) regs[reg_wa] <= reg_wd;
      // Operands sampled before any writeback, so rd==rs reads the old value
      if (alu_load) begin
        alu_a    <= regs[rd];
        alu_b    <= regs[rs];
        alu_mode <= mode_dec;
      end
    end
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] imem_addr;
  logic [7:0] imem_data;
  logic       alu_enable;
  logic [2:0] alu_mode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_out;
  logic       alu_flag_zero;
  logic       alu_flag_carry;
  logic [3:0] pc;
  logic       halted;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_reg;

  logic [7:0] rom [16];

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  assign imem_data = rom[imem_addr];

  control_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .alu_enable     (alu_enable),
    .alu_mode       (alu_mode),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_out        (alu_out),
    .alu_flag_zero  (alu_flag_zero),
    .alu_flag_carry (alu_flag_carry),
    .pc             (pc),
    .halted         (halted),
    .dbg_sel        (dbg_sel),
    .dbg_reg        (dbg_reg)
  );

  // Registered ALU environment: result and flags update at the end of the enable cycle
  always @(posedge clk) begin
    if (rst) begin
      alu_out        <= '0;
      alu_flag_zero  <= 1'b0;
      alu_flag_carry <= 1'b0;
    end else if (alu_enable) begin
      case (alu_mode)
        OP_ADD: begin
          alu_out        <= alu_a + alu_b;
          alu_flag_carry <= ({1'b0, alu_a} + {1'b0, alu_b}) > 9'd255;
          alu_flag_zero  <= (alu_a + alu_b) == 8'd0;
        end
        OP_SUB: begin
          alu_out        <= alu_a - alu_b;
          alu_flag_carry <= alu_a < alu_b;
          alu_flag_zero  <= alu_a == alu_b;
        end
        OP_AND: begin
          alu_out        <= alu_a & alu_b;
          alu_flag_carry <= 1'b0;
          alu_flag_zero  <= (alu_a & alu_b) == 8'd0;
        end
        default: begin
          alu_out        <= alu_a | alu_b;
          alu_flag_carry <= 1'b0;
          alu_flag_zero  <= (alu_a | alu_b) == 8'd0;
        end
      endcase
    end
  end

  // Enable-pulse monitor: counts cycles with alu_enable high and captures operands
  int         pulses = 0;
  logic [7:0] cap_a;
  logic [7:0] cap_b;
  logic [2:0] cap_m;
  always @(posedge clk) begin
    if (alu_enable === 1'b1) begin
      pulses = pulses + 1;
      cap_a  = alu_a;
      cap_b  = alu_b;
      cap_m  = alu_mode;
    end
  end

  // Instruction-level reference model
  int m_pc;
  int m_r [4];
  bit m_z;
  bit m_c;
  bit m_halt;
  int m_pulses;
  int run_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_z = 0;
    m_c = 0;
    m_halt = 0;
  endtask

  task automatic model_step(output int lat, output bit is_alu,
                            output int ea, output int eb, output int em);
    int ins, cls, f, rd, rs, res, cond;
    bit take;
    ins = int'(rom[m_pc]);
    m_pc = (m_pc + 1) % 16;
    cls = ins / 64;
    f   = (ins / 16) % 4;
    is_alu = 0;
    ea = 0; eb = 0; em = 0;
    lat = 2;
    case (cls)
      0: begin
        rd = (ins / 4) % 4;
        rs = ins % 4;
        ea = m_r[rd];
        eb = m_r[rs];
        case (f)
          0: begin res = ea + eb; m_c = res > 255; res = res % 256; em = OP_ADD; end
          1: begin res = (ea - eb + 256) % 256; m_c = ea < eb; em = OP_SUB; end
          2: begin res = ea & eb; m_c = 0; em = OP_AND; end
          default: begin res = ea | eb; m_c = 0; em = OP_OR; end
        endcase
        m_z = (res == 0);
        m_r[rd] = res;
        is_alu = 1;
        m_pulses++;
        lat = 4;
      end
      1: m_r[f] = ins % 16;
      2: begin
        cond = f;
        take = (cond == 0) || (cond == 1 && m_z) || (cond == 2 && m_c) || (cond == 3 && !m_z);
        if (take) m_pc = ins % 16;
      end
      default: if (ins == 255) m_halt = 1;
    endcase
  endtask

  task automatic peek(input int r, output logic [7:0] v);
    dbg_sel = 2'(r);
    #1;
    v = dbg_reg;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] v;
    for (int r = 0; r < 4; r++) begin
      peek(r, v);
      chk($sformatf("%s r%0d", tag, r), 32'(v), 32'(m_r[r]));
    end
    chk({tag, " pc"}, 32'(pc), 32'(m_pc));
    chk({tag, " halted"}, 32'(halted), 32'(m_halt));
    chk({tag, " enable"}, 32'(alu_enable), 32'd0);
    chk({tag, " pulses"}, 32'(pulses), 32'(m_pulses));
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_pulses = pulses;
  endtask

  task automatic run_prog(input string name, input int max_instr);
    int lat, ea, eb, em;
    bit is_alu;
    do_reset();
    model_reset();
    run_cycles = 0;
    chk({name, " rst mode"}, 32'(alu_mode), 32'(OP_ADD));
    chk({name, " rst a"}, 32'(alu_a), 32'd0);
    chk({name, " rst b"}, 32'(alu_b), 32'd0);
    check_all({name, " rst"});
    for (int i = 0; i < max_instr; i++) begin
      model_step(lat, is_alu, ea, eb, em);
      if (is_alu) begin
        tick(); tick();
        chk($sformatf("%s i%0d exec en", name, i), 32'(alu_enable), 32'd1);
        chk($sformatf("%s i%0d exec a", name, i), 32'(alu_a), 32'(ea));
        chk($sformatf("%s i%0d exec b", name, i), 32'(alu_b), 32'(eb));
        chk($sformatf("%s i%0d exec mode", name, i), 32'(alu_mode), 32'(em));
        tick(); tick();
        chk($sformatf("%s i%0d cap a", name, i), 32'(cap_a), 32'(ea));
        chk($sformatf("%s i%0d cap b", name, i), 32'(cap_b), 32'(eb));
        chk($sformatf("%s i%0d cap mode", name, i), 32'(cap_m), 32'(em));
      end else begin
        repeat (lat) tick();
      end
      run_cycles += lat;
      check_all($sformatf("%s i%0d", name, i));
      if (m_halt) begin
        repeat (3) tick();
        check_all({name, " frozen"});
        break;
      end
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  initial begin
    logic [7:0] v;
    rst = 1'b1;
    dbg_sel = 2'd0;
    fill(8'hFF);

    // ADD program: r0=5+3
    rom[0] = 8'h45; rom[1] = 8'h53; rom[2] = 8'h01; rom[3] = 8'hFF;
    run_prog("add", 10);
    peek(0, v); chk("add r0=8", 32'(v), 32'h08);
    peek(1, v); chk("add r1=3", 32'(v), 32'h03);
    chk("add halt cycles", 32'(run_cycles), 32'd10);
    chk("add pulse a", 32'(cap_a), 32'h05);
    chk("add pulse b", 32'(cap_b), 32'h03);

    // SUB with borrow, then JC to 7
    fill(8'hC0);
    rom[0] = 8'h43; rom[1] = 8'h55; rom[2] = 8'h11; rom[3] = 8'hA7;
    rom[7] = 8'h62; rom[8] = 8'hFF;
    run_prog("jc", 12);
    peek(0, v); chk("jc r0=FE", 32'(v), 32'hFE);
    peek(2, v); chk("jc r2=2", 32'(v), 32'h02);
    chk("jc carry", 32'(alu_flag_carry), 32'd1);

    // Zero flag: JNZ not taken, then taken
    fill(8'hFF);
    rom[0] = 8'h44; rom[1] = 8'h54; rom[2] = 8'h11; rom[3] = 8'hB0;
    run_prog("jnz_nt", 10);
    chk("jnz_nt pc", 32'(pc), 32'd5);
    rom[1] = 8'h55;
    run_prog("jnz_t", 9);

    // AND / OR / rd==rs ADD / JZ after nonzero AND
    fill(8'hFF);
    rom[0] = 8'h4C; rom[1] = 8'h5A; rom[2] = 8'h21; rom[3] = 8'h9F;
    rom[4] = 8'h4C; rom[5] = 8'h31; rom[6] = 8'h00; rom[7] = 8'hFF;
    run_prog("logic", 12);
    peek(0, v); chk("logic r0=1C", 32'(v), 32'h1C);

    // PC wrap with NOPs
    fill(8'hC0);
    run_prog("wrap", 20);

    // Reset during EXEC discards the writeback
    fill(8'hFF);
    rom[0] = 8'h41; rom[1] = 8'h52; rom[2] = 8'h01;
    do_reset();
    repeat (6) tick();
    chk("rstx exec en", 32'(alu_enable), 32'd1);
    rst = 1'b1;
    tick();
    chk("rstx en", 32'(alu_enable), 32'd0);
    chk("rstx pc", 32'(pc), 32'd0);
    peek(0, v); chk("rstx r0", 32'(v), 32'd0);
    peek(1, v); chk("rstx r1", 32'(v), 32'd0);
    rst = 1'b0;
    tick();
    chk("rstx fetch pc", 32'(pc), 32'd1);
    peek(0, v); chk("rstx no wb", 32'(v), 32'd0);
    tick();
    peek(0, v); chk("rstx ldi again", 32'(v), 32'd1);

    // Random programs
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      run_prog($sformatf("rnd%0d", p), 40);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
